muldiv_unit: RTL

Iterative RV64M multiply/divide unit placed beside the ALU in the execute stage. It accepts one M-extension operation per instruction and holds the pipeline with a stall request while a 64-iteration shift-add multiply or restoring divide runs. It then presents the 64-bit result for the EX/MEM register. Operands arrive already forwarded (SrcA/forwarded-RD2 of the execute stage); the hazard unit ORs `Stall_MD` into its stall logic.

---
 rtl/muldiv_unit.sv | 87 ++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M mul/div; ports clk, rst, Start_E/MDOp_E/SrcA_E/SrcB_E/Flush_E in, Stall_MD/Done_MD/MDResult_E out
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Start_E,
  input  logic [2:0]      MDOp_E,
  input  logic [XLEN-1:0] SrcA_E,
  input  logic [XLEN-1:0] SrcB_E,
  input  logic            Flush_E,
  output logic            Stall_MD,
  output logic            Done_MD,
  output logic [XLEN-1:0] MDResult_E
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t              state;
  logic [5:0]          cnt;
  logic [2:0]          op;
  logic                neg;
  logic [XLEN-1:0]     opb;
  logic [2*XLEN-1:0]   acc;
  logic                is_div, sgn_a, sgn_b, sa, sb, div0, ovf, ge;
  logic [XLEN-1:0]     abs_a, abs_b, fast_res, dq, dr, res;
  logic [XLEN:0]       msum, rsh, rdif;
  logic [2*XLEN-1:0]   acc_nx, prod;
  always_comb begin
    is_div   = MDOp_E[2];
    sgn_a    = is_div ? !MDOp_E[0] : MDOp_E != 3'b011;
    sgn_b    = is_div ? !MDOp_E[0] : !MDOp_E[1];
    sa       = sgn_a & SrcA_E[XLEN-1];
    sb       = sgn_b & SrcB_E[XLEN-1];
    abs_a    = sa ? -SrcA_E : SrcA_E;
    abs_b    = sb ? -SrcB_E : SrcB_E;
    div0     = is_div && SrcB_E == '0;
    ovf      = is_div && !MDOp_E[0] && SrcA_E == {1'b1, {(XLEN-1){1'b0}}} && &SrcB_E;
    fast_res = div0 ? (MDOp_E[1] ? SrcA_E : '1) : (MDOp_E[1] ? '0 : SrcA_E);
    msum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    rsh      = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    ge       = rsh >= {1'b0, opb};
    rdif     = rsh - {1'b0, opb};
    acc_nx   = op[2] ? {ge ? rdif[XLEN-1:0] : rsh[XLEN-1:0], acc[XLEN-2:0], ge}
                     : {msum, acc[XLEN-1:1]};
    prod     = neg ? -acc_nx : acc_nx;
    dq       = neg ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    dr       = neg ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
    res      = op[2] ? (op[1] ? dr : dq) : (op == 3'b000 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  assign Stall_MD = !rst && !Flush_E && (state == BUSY || (state == IDLE && Start_E));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op         <= '0;
      neg        <= 1'b0;
      opb        <= '0;
      acc        <= '0;
      Done_MD    <= 1'b0;
      MDResult_E <= '0;
    end else begin
      Done_MD <= 1'b0;
      if (Flush_E) state <= IDLE;
      else if (state == IDLE) begin
        if (Start_E) begin
          op  <= MDOp_E;
          neg <= (is_div && MDOp_E[1]) ? sa : sa ^ sb;
          opb <= abs_b;
          acc <= {{XLEN{1'b0}}, abs_a};
          cnt <= 6'd63;
          if (div0 || ovf) begin
            state      <= DONE;
            Done_MD    <= 1'b1;
            MDResult_E <= fast_res;
          end else state <= BUSY;
        end
      end else if (state == BUSY) begin
        acc <= acc_nx;
        cnt <= cnt - 6'd1;
        if (cnt == 6'd0) begin
          state      <= DONE;
          Done_MD    <= 1'b1;
          MDResult_E <= res;
        end
      end else state <= IDLE;
    end
  end
endmodule
